// File: rtl/jedro_1_mem_arbiter_if.sv
// Bus bundle between the jedro_1 fetch/LSU requesters, the arbiter
// and the shared single-port memory.
interface jedro_1_mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  instr_req_i;
   logic [DATA_WIDTH-1:0] instr_addr_i;
   logic                  instr_gnt_o;
   logic                  instr_rvalid_o;
   logic [DATA_WIDTH-1:0] instr_rdata_o;
   logic                  instr_err_o;

   logic                  data_req_i;
   logic                  data_we_i;
   logic [3:0]            data_be_i;
   logic [DATA_WIDTH-1:0] data_addr_i;
   logic [DATA_WIDTH-1:0] data_wdata_i;
   logic                  data_gnt_o;
   logic                  data_rvalid_o;
   logic [DATA_WIDTH-1:0] data_rdata_o;
   logic                  data_err_o;

   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [3:0]            mem_be_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  mem_err_i;

   logic                  protocol_err_o;

   modport slave (
      input  instr_req_i,
      input  instr_addr_i,
      output instr_gnt_o,
      output instr_rvalid_o,
      output instr_rdata_o,
      output instr_err_o,
      input  data_req_i,
      input  data_we_i,
      input  data_be_i,
      input  data_addr_i,
      input  data_wdata_i,
      output data_gnt_o,
      output data_rvalid_o,
      output data_rdata_o,
      output data_err_o,
      output mem_req_o,
      output mem_we_o,
      output mem_be_o,
      output mem_addr_o,
      output mem_wdata_o,
      input  mem_gnt_i,
      input  mem_rvalid_i,
      input  mem_rdata_i,
      input  mem_err_i,
      output protocol_err_o
   );

   modport master (
      output instr_req_i,
      output instr_addr_i,
      input  instr_gnt_o,
      input  instr_rvalid_o,
      input  instr_rdata_o,
      input  instr_err_o,
      output data_req_i,
      output data_we_i,
      output data_be_i,
      output data_addr_i,
      output data_wdata_i,
      input  data_gnt_o,
      input  data_rvalid_o,
      input  data_rdata_o,
      input  data_err_o,
      input  mem_req_o,
      input  mem_we_o,
      input  mem_be_o,
      input  mem_addr_o,
      input  mem_wdata_o,
      output mem_gnt_i,
      output mem_rvalid_i,
      output mem_rdata_i,
      output mem_err_i,
      input  protocol_err_o
   );
endinterface

// File: rtl/jedro_1_mem_arbiter.sv
// Fetch/data arbiter for the shared jedro_1 memory port: data priority,
// fetch starvation guard, grant-wait lock and in-order response routing.
module jedro_1_mem_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int OUTSTANDING     = 2,
   parameter int DATA_MAX_CONSEC = 4
) (
   input logic                   clk_i,
   input logic                   rstn_i,
   jedro_1_mem_arbiter_if.slave  bus
);
   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam int KW = $clog2(DATA_MAX_CONSEC + 1);

   typedef enum logic [1:0] {
      ST_FREE,
      ST_LOCK_I,
      ST_LOCK_D
   } lock_state_e;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_INSTR,
      SEL_DATA
   } sel_e;

   lock_state_e            state_q, state_d;
   logic [KW-1:0]          consec_q, consec_d;
   logic [OUTSTANDING-1:0] owner_q, owner_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   perr_q, perr_d;

   sel_e                   sel;
   logic                   req_sel;
   logic                   full;
   logic                   empty;
   logic                   mem_req;
   logic                   grant;
   logic                   instr_gnt;
   logic                   data_gnt;
   logic                   push;
   logic                   pop;
   logic                   head_is_data;
   logic [CW-1:0]          push_idx;

   // Selection: the lock wins, then the starvation guard, then data.
   always_comb begin
      sel = SEL_NONE;
      case (state_q)
         ST_LOCK_I: sel = SEL_INSTR;
         ST_LOCK_D: sel = SEL_DATA;
         default: begin
            if (bus.instr_req_i && bus.data_req_i) begin
               if (consec_q == KW'(DATA_MAX_CONSEC)) begin
                  sel = SEL_INSTR;
               end else begin
                  sel = SEL_DATA;
               end
            end else if (bus.instr_req_i) begin
               sel = SEL_INSTR;
            end else if (bus.data_req_i) begin
               sel = SEL_DATA;
            end
         end
      endcase
   end

   always_comb begin
      full      = (cnt_q == CW'(OUTSTANDING));
      empty     = (cnt_q == '0);
      req_sel   = ((sel == SEL_INSTR) && bus.instr_req_i) ||
                  ((sel == SEL_DATA) && bus.data_req_i);
      mem_req   = req_sel && !full;
      grant     = mem_req && bus.mem_gnt_i;
      instr_gnt = grant && (sel == SEL_INSTR);
      data_gnt  = grant && (sel == SEL_DATA);
   end

   always_comb begin
      bus.mem_req_o   = mem_req;
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = 4'h0;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      case (sel)
         SEL_INSTR: begin
            bus.mem_be_o   = 4'hF;
            bus.mem_addr_o = bus.instr_addr_i;
         end
         SEL_DATA: begin
            bus.mem_we_o    = bus.data_we_i;
            bus.mem_be_o    = bus.data_be_i;
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_wdata_o = bus.data_wdata_i;
         end
         default: ;
      endcase
      bus.instr_gnt_o = instr_gnt;
      bus.data_gnt_o  = data_gnt;
   end

   // Lock FSM keeps the memory attributes stable until the grant.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FREE: begin
            if (mem_req && !bus.mem_gnt_i) begin
               if (sel == SEL_DATA) begin
                  state_d = ST_LOCK_D;
               end else begin
                  state_d = ST_LOCK_I;
               end
            end
         end
         default: begin
            if (bus.mem_gnt_i) begin
               state_d = ST_FREE;
            end
         end
      endcase
   end

   always_comb begin
      consec_d = consec_q;
      if (!bus.instr_req_i || instr_gnt) begin
         consec_d = '0;
      end else if (data_gnt &&
                   (consec_q != KW'(DATA_MAX_CONSEC))) begin
         consec_d = consec_q + KW'(1);
      end
   end

   // Owner FIFO as a shift register; head always sits at bit 0.
   always_comb begin
      push         = grant;
      pop          = bus.mem_rvalid_i && !empty;
      head_is_data = owner_q[0];
      push_idx     = pop ? (cnt_q - CW'(1)) : cnt_q;
      owner_d      = owner_q;
      if (pop) begin
         for (int i = 0; i < OUTSTANDING - 1; i++) begin
            owner_d[i] = owner_q[i+1];
         end
      end
      if (push) begin
         for (int i = 0; i < OUTSTANDING; i++) begin
            if (CW'(i) == push_idx) begin
               owner_d[i] = (sel == SEL_DATA);
            end
         end
      end
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_comb begin
      perr_d             = perr_q || (bus.mem_rvalid_i && empty);
      bus.protocol_err_o = perr_q;
      bus.instr_rvalid_o = pop && !head_is_data;
      bus.data_rvalid_o  = pop && head_is_data;
      bus.instr_rdata_o  = '0;
      bus.instr_err_o    = 1'b0;
      bus.data_rdata_o   = '0;
      bus.data_err_o     = 1'b0;
      if (bus.instr_rvalid_o) begin
         bus.instr_rdata_o = bus.mem_rdata_i;
         bus.instr_err_o   = bus.mem_err_i;
      end
      if (bus.data_rvalid_o) begin
         bus.data_rdata_o = bus.mem_rdata_i;
         bus.data_err_o   = bus.mem_err_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q  <= ST_FREE;
         consec_q <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         consec_q <= consec_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         perr_q   <= perr_d;
      end
   end
endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed and random checks of jedro_1_mem_arbiter against a
// queue-based reference of the arbitration and routing rules.
module tb_jedro_1_mem_arbiter;
   localparam int DW   = 32;
   localparam int OUT  = 2;
   localparam int MAXC = 4;

   logic clk_i = 1'b0;
   logic rstn_i;
   always #5 clk_i = ~clk_i;

   jedro_1_mem_arbiter_if #(.DATA_WIDTH(DW)) bus();

   jedro_1_mem_arbiter #(
      .DATA_WIDTH(DW),
      .OUTSTANDING(OUT),
      .DATA_MAX_CONSEC(MAXC)
   ) dut (
      .clk_i(clk_i),
      .rstn_i(rstn_i),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // reference state: 1 = fetch, 2 = data
   int    owners[$];
   int    lock_own = 0;
   int    consec   = 0;
   bit    perr     = 0;
   bit    auto_rsp = 0;
   bit    prev_g   = 0;
   logic [31:0] prev_addr = '0;
   bit    ig_e = 0;
   bit    dg_e = 0;

   logic        o_ig, o_dg, o_mreq, o_irv, o_drv;
   logic        o_ierr, o_derr, o_perr;
   logic [31:0] o_addr, o_ird, o_drd;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      int          sel;
      bit          rq, full, mreq, g, pop;
      bit          ewe, irv, drv;
      logic [3:0]  ebe;
      logic [31:0] ea, ew;
      int          head;
      if (auto_rsp) begin
         bus.mem_rvalid_i = prev_g;
         bus.mem_rdata_i  = prev_addr;
         bus.mem_err_i    = 1'b0;
      end
      #3;
      if (lock_own != 0) sel = lock_own;
      else if (bus.instr_req_i && bus.data_req_i)
         sel = (consec == MAXC) ? 1 : 2;
      else if (bus.instr_req_i) sel = 1;
      else if (bus.data_req_i) sel = 2;
      else sel = 0;
      rq = (sel == 1) ? bus.instr_req_i :
           (sel == 2) ? bus.data_req_i : 1'b0;
      full = (owners.size() == OUT);
      mreq = rq && !full;
      g    = mreq && bus.mem_gnt_i;
      ewe = 0; ebe = 4'h0; ea = '0; ew = '0;
      if (sel == 1) begin
         ebe = 4'hF; ea = bus.instr_addr_i;
      end else if (sel == 2) begin
         ewe = bus.data_we_i; ebe = bus.data_be_i;
         ea = bus.data_addr_i; ew = bus.data_wdata_i;
      end
      pop  = bus.mem_rvalid_i && (owners.size() > 0);
      head = pop ? owners[0] : 0;
      irv  = pop && (head == 1);
      drv  = pop && (head == 2);
      chk("mem_req", 32'(bus.mem_req_o), 32'(mreq));
      chk("instr_gnt", 32'(bus.instr_gnt_o), 32'(g && sel == 1));
      chk("data_gnt", 32'(bus.data_gnt_o), 32'(g && sel == 2));
      chk("mem_addr", bus.mem_addr_o, ea);
      chk("mem_we", 32'(bus.mem_we_o), 32'(ewe));
      chk("mem_be", 32'(bus.mem_be_o), 32'(ebe));
      chk("mem_wdata", bus.mem_wdata_o, ew);
      chk("instr_rvalid", 32'(bus.instr_rvalid_o), 32'(irv));
      chk("instr_rdata", bus.instr_rdata_o,
          irv ? bus.mem_rdata_i : 32'h0);
      chk("instr_err", 32'(bus.instr_err_o),
          32'(irv && bus.mem_err_i));
      chk("data_rvalid", 32'(bus.data_rvalid_o), 32'(drv));
      chk("data_rdata", bus.data_rdata_o,
          drv ? bus.mem_rdata_i : 32'h0);
      chk("data_err", 32'(bus.data_err_o),
          32'(drv && bus.mem_err_i));
      chk("protocol_err", 32'(bus.protocol_err_o), 32'(perr));
      o_ig = bus.instr_gnt_o;   o_dg = bus.data_gnt_o;
      o_mreq = bus.mem_req_o;   o_addr = bus.mem_addr_o;
      o_irv = bus.instr_rvalid_o; o_drv = bus.data_rvalid_o;
      o_ird = bus.instr_rdata_o;  o_drd = bus.data_rdata_o;
      o_ierr = bus.instr_err_o;   o_derr = bus.data_err_o;
      o_perr = bus.protocol_err_o;
      @(posedge clk_i);
      if (!rstn_i) begin
         owners.delete();
         lock_own = 0; consec = 0; perr = 0; prev_g = 0;
      end else begin
         if (mreq && !bus.mem_gnt_i) lock_own = sel;
         else if (bus.mem_gnt_i) lock_own = 0;
         if (!bus.instr_req_i || (g && sel == 1)) consec = 0;
         else if (g && sel == 2 && consec < MAXC) consec++;
         if (bus.mem_rvalid_i) begin
            if (owners.size() == 0) perr = 1;
            else void'(owners.pop_front());
         end
         if (g) owners.push_back(sel);
         prev_g = g;
         prev_addr = ea;
      end
      ig_e = g && (sel == 1);
      dg_e = g && (sel == 2);
      #1;
   endtask

   task automatic idle();
      bus.instr_req_i = 0; bus.data_req_i = 0;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_err_i = 0;
   endtask

   initial begin
      logic [9:0] ivec, dvec;
      int ng;
      rstn_i = 0;
      idle();
      bus.instr_addr_i = '0; bus.data_we_i = 0; bus.data_be_i = '0;
      bus.data_addr_i = '0; bus.data_wdata_i = '0; bus.mem_rdata_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      cyc();
      chk("reset_mem_req", 32'(o_mreq), 32'h0);
      chk("reset_perr", 32'(o_perr), 32'h0);
      rstn_i = 1;

      // fetch only, memory answers one cycle after grant
      auto_rsp = 1;
      bus.mem_gnt_i = 1;
      bus.instr_req_i = 1; bus.instr_addr_i = 32'h8000_0000;
      cyc();
      chk("t1_gnt0", 32'(o_ig), 32'h1);
      bus.instr_addr_i = 32'h8000_0004;
      cyc();
      chk("t1_gnt1", 32'(o_ig), 32'h1);
      chk("t1_rdata0", o_ird, 32'h8000_0000);
      bus.instr_req_i = 0;
      cyc();
      chk("t1_rvalid1", 32'(o_irv), 32'h1);
      chk("t1_rdata1", o_ird, 32'h8000_0004);
      chk("t1_no_drv", 32'(o_drv), 32'h0);

      // fairness D,D,D,D,I repeating
      bus.instr_req_i = 1; bus.instr_addr_i = 32'h8000_0040;
      bus.data_req_i = 1; bus.data_addr_i = 32'h0000_0200;
      bus.data_be_i = 4'h3; bus.data_we_i = 1;
      bus.data_wdata_i = 32'hCAFE_0001;
      for (int i = 0; i < 10; i++) begin
         cyc();
         ivec[i] = o_ig;
         dvec[i] = o_dg;
      end
      chk("t2_instr_seq", 32'(ivec), 32'h210);
      chk("t2_data_seq", 32'(dvec), 32'h1EF);
      idle();
      cyc();

      // lock holds address while waiting for grant
      bus.data_req_i = 1; bus.data_addr_i = 32'h100;
      bus.data_we_i = 0; bus.data_be_i = 4'hF;
      bus.mem_gnt_i = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            bus.instr_req_i = 1; bus.instr_addr_i = 32'h8000_0100;
         end
         if (i == 3) bus.mem_gnt_i = 1;
         cyc();
         chk("t3_addr", o_addr, 32'h100);
         chk("t3_dgnt", 32'(o_dg), 32'(i == 3));
      end
      bus.data_req_i = 0;
      cyc();
      chk("t3_instr_after", 32'(o_ig), 32'h1);
      idle();
      cyc();
      cyc();
      auto_rsp = 0;

      // outstanding limit
      bus.data_req_i = 1; bus.mem_gnt_i = 1;
      ng = 0;
      for (int i = 0; i < 4; i++) begin
         bus.data_addr_i = 32'h400 + 32'(i * 4);
         cyc();
         ng += int'(o_dg);
      end
      chk("t4_grants", 32'(ng), 32'd2);
      chk("t4_req_off", 32'(o_mreq), 32'h0);
      bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1111;
      cyc();
      chk("t4_full_pop", 32'(o_dg), 32'h0);
      bus.mem_rvalid_i = 0;
      cyc();
      chk("t4_regrant", 32'(o_dg), 32'h1);
      idle();
      bus.mem_rvalid_i = 1;
      cyc();
      cyc();
      bus.mem_rvalid_i = 0;

      // ordering and error routing
      bus.mem_gnt_i = 1; bus.instr_req_i = 1;
      cyc();
      bus.instr_req_i = 0; bus.data_req_i = 1;
      cyc();
      idle();
      bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hA5A5_0001;
      cyc();
      chk("t5_irv", 32'(o_irv), 32'h1);
      chk("t5_ierr", 32'(o_ierr), 32'h0);
      bus.mem_err_i = 1; bus.mem_rdata_i = 32'h5A5A_0002;
      cyc();
      chk("t5_drv", 32'(o_drv), 32'h1);
      chk("t5_derr", 32'(o_derr), 32'h1);
      chk("t5_drd", o_drd, 32'h5A5A_0002);
      idle();

      // reset mid-operation, stale response afterwards
      bus.data_req_i = 1; bus.mem_gnt_i = 1;
      cyc();
      idle();
      rstn_i = 0;
      cyc();
      rstn_i = 1;
      bus.mem_rvalid_i = 1;
      cyc();
      chk("t6_no_irv", 32'(o_irv), 32'h0);
      chk("t6_no_drv", 32'(o_drv), 32'h0);
      bus.mem_rvalid_i = 0;
      repeat (3) begin
         cyc();
         chk("t6_perr", 32'(o_perr), 32'h1);
      end
      rstn_i = 0;
      cyc();
      rstn_i = 1;
      cyc();
      chk("t6_perr_clr", 32'(o_perr), 32'h0);

      // random traffic with requesters holding until granted
      for (int n = 0; n < 600; n++) begin
         if (!(bus.instr_req_i && !ig_e)) begin
            bus.instr_req_i = 1'($urandom_range(0, 1));
            bus.instr_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (!(bus.data_req_i && !dg_e)) begin
            bus.data_req_i = 1'($urandom_range(0, 1));
            bus.data_addr_i = $urandom;
            bus.data_we_i = 1'($urandom_range(0, 1));
            bus.data_be_i = 4'($urandom);
            bus.data_wdata_i = $urandom;
         end
         bus.mem_gnt_i = 1'($urandom_range(0, 1));
         bus.mem_rvalid_i = (owners.size() > 0) &&
                            ($urandom_range(0, 2) != 0);
         bus.mem_rdata_i = $urandom;
         bus.mem_err_i = 1'($urandom_range(0, 1));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
